// File: rtl/div_share_pkg.sv
// div_share_pkg: shared width, FSM state, id type and magnitude helper for the shared divider
package div_share_pkg;
  localparam int W = 4;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  typedef logic id_t;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: unsigned restoring divider, one quotient bit per step, MSB first
module div_iter_core
  import div_share_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);
  logic [W-1:0] r_q, r_d, q_q, q_d, d_q, d_d, t;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ge;
  // partial remainder stays below the divisor (at most 8), so its MSB is always clear
  always_comb begin
    t = {r_q[W-2:0], q_q[W-1]};
    ge = t >= d_q;
    r_d = load ? '0 : step ? (ge ? t - d_q : t) : r_q;
    q_d = load ? dividend : step ? {q_q[W-2:0], ge} : q_q;
    d_d = load ? divisor : d_q;
    cnt_d = load ? CW'(W - 1) : step ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
    end
  end
  assign quotient = q_q;
  assign remainder = r_q;
  assign done = cnt_q == '0;
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one iterative signed divider between two requesters
module div_share_ctrl
  import div_share_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_dividend,
  input  logic [W-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_dividend,
  input  logic [W-1:0] req1_divisor,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_quotient,
  output logic [W-1:0] rsp_remainder,
  output logic         rsp_dbz
);
  state_e state_q, state_d;
  id_t last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d;
  logic sa_q, sa_d, sb_q, sb_d, rsp_valid_q, rsp_valid_d, rsp_dbz_q, rsp_dbz_d;
  logic [W-1:0] rsp_quo_q, rsp_quo_d, rsp_rem_q, rsp_rem_d, a, b, quo, rem;
  logic gnt0, gnt1, acc, dbz, done;
  div_iter_core u_core (
    .clk(clk), .rst_n(rst_n), .load(acc & ~dbz), .step(state_q == CALC),
    .dividend(mag(a)), .divisor(mag(b)),
    .quotient(quo), .remainder(rem), .done(done)
  );
  // last_q points at the previous grantee; on contention the other side wins
  always_comb begin
    gnt0 = rst_n & (state_q == IDLE) & req0_valid & (~req1_valid | last_q);
    gnt1 = rst_n & (state_q == IDLE) & req1_valid & (~req0_valid | ~last_q);
    acc = gnt0 | gnt1;
    a = gnt1 ? req1_dividend : req0_dividend;
    b = gnt1 ? req1_divisor : req0_divisor;
    dbz = b == '0;
    last_d = acc ? gnt1 : last_q;
    id_d = acc ? gnt1 : id_q;
    sa_d = acc ? a[W-1] : sa_q;
    sb_d = acc ? b[W-1] : sb_q;
    state_d = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_quo_d = rsp_quo_q;
    rsp_rem_d = rsp_rem_q;
    rsp_dbz_d = rsp_dbz_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = dbz ? DONE : CALC;
        if (dbz) begin
          rsp_valid_d = 1'b1;
          rsp_id_d = gnt1;
          rsp_quo_d = '0;
          rsp_rem_d = a;
          rsp_dbz_d = 1'b1;
        end
      end
      CALC: state_d = done ? FIX : CALC;
      FIX: begin
        state_d = DONE;
        rsp_valid_d = 1'b1;
        rsp_id_d = id_q;
        rsp_quo_d = (sa_q ^ sb_q) ? -quo : quo;
        rsp_rem_d = sa_q ? -rem : rem;
        rsp_dbz_d = 1'b0;
      end
      DONE: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_quo_q <= '0;
      rsp_rem_q <= '0;
      rsp_dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_quo_q <= rsp_quo_d;
      rsp_rem_q <= rsp_rem_d;
      rsp_dbz_q <= rsp_dbz_d;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_quotient = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_dbz = rsp_dbz_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: scoreboard bench for the shared divider controller
module tb_div_share_ctrl;
  import div_share_pkg::*;
  typedef struct packed {logic id; logic [W-1:0] q; logic [W-1:0] r; logic dbz;} exp_t;
  logic clk = 0, rst_n = 1, req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dbz;
  logic [W-1:0] req0_dividend = 0, req0_divisor = 0, req1_dividend = 0, req1_divisor = 0;
  logic [W-1:0] rsp_quotient, rsp_remainder;
  int total = 0, bad = 0, cyc = 0, acc_n = 0, acc_cyc = 0, rise_cyc = 0, rdy0_n = 0, rdy1_n = 0, v_n = 0;
  logic prev_v = 0;
  exp_t sb[$];
  exp_t e;
  logic gl[$];
  always #5 clk = ~clk;
  div_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  // monitor: cycle count, grant log and scoreboard pops, all sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rsp_valid && !prev_v) rise_cyc = cyc;
      if (rsp_valid) v_n++;
      chk("rdy_excl", 32'(req0_ready & req1_ready), 0);
      if (req0_ready) rdy0_n++;
      if (req1_ready) rdy1_n++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_n++;
        acc_cyc = cyc;
        gl.push_back(req1_ready);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
          chk("rsp_dbz", 32'(rsp_dbz), 32'(e.dbz));
        end
      end
    end
    prev_v = rsp_valid;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_acc(input int n0);
    int k = 0;
    while (acc_n <= n0 && k < 100) begin
      tick(1);
      k++;
    end
    if (acc_n <= n0) chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_gl(input int n);
    int k = 0;
    while (gl.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    if (gl.size() < n) chk("grant_timeout", 32'(gl.size()), 32'(n));
  endtask
  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
  endtask
  task automatic send(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int n0 = acc_n;
    sb.push_back('{who, q, r, z});
    if (who) begin
      req1_dividend = a; req1_divisor = b; req1_valid = 1;
    end else begin
      req0_dividend = a; req0_divisor = b; req0_valid = 1;
    end
    wait_acc(n0);
    req0_valid = 0;
    req1_valid = 0;
  endtask
  initial begin
    int n0, k;
    #1 rst_n = 0;
    req0_valid = 1;
    @(negedge clk);
    #1;
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_quotient", 32'(rsp_quotient), 0);
    chk("rst_remainder", 32'(rsp_remainder), 0);
    chk("rst_dbz", 32'(rsp_dbz), 0);
    req0_valid = 0;
    tick(1);
    rst_n = 1;
    tick(1);
    send(0, 4'd7, 4'd2, 4'd3, 4'd1, 0);
    wait_drain();
    chk("latency_div", 32'(rise_cyc - acc_cyc), 6);
    send(0, 4'd5, 4'd0, 4'd0, 4'd5, 1);
    wait_drain();
    chk("latency_dbz", 32'(rise_cyc - acc_cyc), 1);
    send(1, 4'h9, 4'd2, 4'hD, 4'hF, 0);
    send(1, 4'd7, 4'hE, 4'hD, 4'd1, 0);
    send(1, 4'h8, 4'hF, 4'h8, 4'd0, 0);
    wait_drain();
    // contention with both requesters held valid for four operations
    rdy0_n = 0; rdy1_n = 0; gl.delete();
    repeat (2) begin
      sb.push_back('{1'b0, 4'd2, 4'd0, 1'b0});
      sb.push_back('{1'b1, 4'hF, 4'hE, 1'b0});
    end
    req0_dividend = 4'd6; req0_divisor = 4'd3; req1_dividend = 4'hA; req1_divisor = 4'd4;
    req0_valid = 1; req1_valid = 1;
    wait_gl(4);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(gl[i]), 32'(i % 2));
    chk("rr_ready0_cycles", 32'(rdy0_n), 2);
    chk("rr_ready1_cycles", 32'(rdy1_n), 2);
    wait_drain();
    // response back-pressure with a competing request waiting
    rsp_ready = 0;
    send(0, 4'hB, 4'd3, 4'hF, 4'hE, 0);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick(1);
      k++;
    end
    chk("bp_valid_seen", 32'(rsp_valid), 1);
    n0 = acc_n;
    sb.push_back('{1'b1, 4'hD, 4'd0, 1'b0});
    req1_dividend = 4'd3; req1_divisor = 4'hF; req1_valid = 1;
    repeat (10) begin
      tick(1);
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_id", 32'(rsp_id), 0);
      chk("bp_hold_q", 32'(rsp_quotient), 32'hF);
      chk("bp_hold_r", 32'(rsp_remainder), 32'hE);
      chk("bp_hold_ready", 32'(req0_ready | req1_ready), 0);
    end
    rsp_ready = 1;
    wait_acc(n0);
    req1_valid = 0;
    chk("bp_next_grant", 32'(gl[$]), 1);
    wait_drain();
    // reset while an operation is in CALC
    n0 = acc_n;
    req0_dividend = 4'd7; req0_divisor = 4'd1; req0_valid = 1;
    wait_acc(n0);
    req0_valid = 0;
    tick(2);
    rst_n = 0;
    tick(1);
    chk("rst2_valid", 32'(rsp_valid), 0);
    chk("rst2_id", 32'(rsp_id), 0);
    chk("rst2_quotient", 32'(rsp_quotient), 0);
    chk("rst2_remainder", 32'(rsp_remainder), 0);
    v_n = 0;
    tick(1);
    rst_n = 1;
    tick(10);
    chk("rst2_no_response", 32'(v_n), 0);
    gl.delete();
    sb.push_back('{1'b0, 4'd2, 4'd0, 1'b0});
    sb.push_back('{1'b1, 4'd1, 4'd0, 1'b0});
    req0_dividend = 4'd4; req0_divisor = 4'd2; req1_dividend = 4'd1; req1_divisor = 4'd1;
    req0_valid = 1; req1_valid = 1;
    wait_gl(2);
    req0_valid = 0; req1_valid = 0;
    chk("rst2_first_grant", 32'(gl[0]), 0);
    chk("rst2_second_grant", 32'(gl[1]), 1);
    wait_drain();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
